// File: rtl/dds_phase_gen_pkg.sv
// Types and helpers shared by the DDS phase generator files.
`include "dds_defines.sv"

package dds_phase_gen_pkg;

    localparam int PHASE_W = `ROM_PHASE_BIT;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic               valid;
        logic               wrap;
    } phase_out_t;

    // ROM address = accumulator MSBs rotated by the offset, modulo the ROM size.
    function automatic logic [PHASE_W-1:0] phase_with_offset(
        input logic [PHASE_W-1:0] acc_msbs,
        input logic [PHASE_W-1:0] offset
    );
        return acc_msbs + offset;
    endfunction

endpackage

// File: rtl/dds_defines.sv
// Shared DDS constants: sine ROM address width and largest ROM address.
`ifndef DDS_DEFINES_SV
`define DDS_DEFINES_SV
`define ROM_PHASE_BIT 10
`define ROM_PHASE_MAX_VAL 10'd1023
`endif

// File: rtl/dds_sample_tick.sv
// Sample-rate divider: one tick every SAMPLE_DIV enabled clocks.
module dds_sample_tick #(
    parameter int SAMPLE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wrap at the last count, hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator with tuning-word load FSM (immediate or on wrap),
// phase offset and registered sine-ROM address output.
`include "dds_defines.sv"

module dds_phase_gen
    import dds_phase_gen_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int SAMPLE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [ACC_W-1:0]   tw_data,
    input  logic               tw_valid,
    output logic               tw_ready,
    input  logic               sync_mode,
    input  logic [PHASE_W-1:0] offset,
    input  logic               phase_clr,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    logic             state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] tw_active_q, tw_active_d;
    logic [ACC_W-1:0] tw_pend_q, tw_pend_d;
    phase_out_t       out_q, out_d;

    logic             tick_s;
    logic             tick_eff_s;
    logic             carry_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             commit_s;
    logic             tw_ready_s;
    logic             load_now_s;
    logic             load_pend_s;

    dds_sample_tick #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_sample_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick_s)
    );

    // Accumulator sum; a clear on the same edge swallows the tick entirely.
    always_comb begin
        {carry_s, acc_next_s} = {1'b0, acc_q} + {1'b0, tw_active_q};
        tick_eff_s = tick_s && !phase_clr;
        commit_s   = (state_q == ST_PENDING) && tick_eff_s && carry_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tw_valid && sync_mode) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (commit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and load strobes.
    always_comb begin
        tw_ready_s  = 1'b0;
        load_now_s  = 1'b0;
        load_pend_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tw_ready_s  = 1'b1;
                load_now_s  = tw_valid && !sync_mode;
                load_pend_s = tw_valid && sync_mode;
            end
            ST_PENDING: begin
                tw_ready_s  = 1'b0;
            end
            default: begin
                tw_ready_s  = 1'b0;
            end
        endcase
    end

    // Datapath next state: accumulator, tuning words, output register.
    always_comb begin
        if (phase_clr) begin
            acc_d = '0;
        end else if (tick_s) begin
            acc_d = acc_next_s;
        end else begin
            acc_d = acc_q;
        end

        if (load_now_s) begin
            tw_active_d = tw_data;
        end else if (commit_s) begin
            tw_active_d = tw_pend_q;
        end else begin
            tw_active_d = tw_active_q;
        end

        if (load_pend_s) begin
            tw_pend_d = tw_data;
        end else begin
            tw_pend_d = tw_pend_q;
        end

        out_d = out_q;
        if (tick_eff_s) begin
            out_d.phase = phase_with_offset(acc_next_s[ACC_W-1 -: PHASE_W], offset);
            out_d.valid = 1'b1;
            out_d.wrap  = carry_s;
        end else begin
            out_d.valid = 1'b0;
            out_d.wrap  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q       <= '0;
            tw_active_q <= '0;
            tw_pend_q   <= '0;
            out_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            tw_active_q <= tw_active_d;
            tw_pend_q   <= tw_pend_d;
            out_q       <= out_d;
        end
    end

    assign tw_ready    = tw_ready_s;
    assign phase       = out_q.phase;
    assign phase_valid = out_q.valid;
    assign wrap        = out_q.wrap;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Self-checking bench for dds_phase_gen: constant vector table plus
// model-driven scoreboard sequences for wrap, sync load, clear and divider.
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] tw_data;
    logic        tw_valid;
    logic        sync_mode;
    logic [9:0]  offset;
    logic        phase_clr;
    logic        tw_ready;
    logic [9:0]  phase;
    logic        phase_valid;
    logic        wrap;
    logic        enable4;
    logic        tw_ready4;
    logic [9:0]  phase4;
    logic        phase_valid4;
    logic        wrap4;

    always #5 clk = ~clk;

    dds_phase_gen #(.ACC_W(32), .SAMPLE_DIV(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .tw_data(tw_data), .tw_valid(tw_valid),
        .tw_ready(tw_ready), .sync_mode(sync_mode), .offset(offset), .phase_clr(phase_clr),
        .phase(phase), .phase_valid(phase_valid), .wrap(wrap)
    );

    dds_phase_gen #(.ACC_W(32), .SAMPLE_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable4), .tw_data(tw_data), .tw_valid(tw_valid),
        .tw_ready(tw_ready4), .sync_mode(sync_mode), .offset(offset), .phase_clr(phase_clr),
        .phase(phase4), .phase_valid(phase_valid4), .wrap(wrap4)
    );

    typedef struct {
        logic        en;
        logic [31:0] tw;
        logic        tv;
        logic        sm;
        logic [9:0]  off;
        logic        clr;
        logic [9:0]  ph;
        logic        pv;
        logic        wr;
        logic        rdy;
    } vec_t;

    typedef struct {
        logic [9:0] ph;
        logic       pv;
        logic       wr;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[17];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] m_acc, m_tw, m_pend;
    logic        m_pending;
    logic [9:0]  m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [31:0] tw, input logic tv,
                                input logic sm, input logic [9:0] off, input logic clr,
                                input logic [9:0] ph, input logic pv, input logic wr,
                                input logic rdy);
        vec_t v;
        v.en = en; v.tw = tw; v.tv = tv; v.sm = sm; v.off = off; v.clr = clr;
        v.ph = ph; v.pv = pv; v.wr = wr; v.rdy = rdy;
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 32'd0; m_tw = 32'd0; m_pend = 32'd0; m_pending = 1'b0; m_phase = 10'd0;
    endtask

    // Reference behaviour for SAMPLE_DIV=1 (every enabled clock is a tick).
    task automatic model_step(input logic en, input logic tv, input logic sm,
                              input logic [31:0] tw, input logic [9:0] off,
                              input logic clr, output exp_t e);
        logic [32:0] sum;
        logic        was_pending;
        sum = {1'b0, m_acc} + {1'b0, m_tw};
        was_pending = m_pending;
        e.pv = 1'b0;
        e.wr = 1'b0;
        if (clr) begin
            m_acc = 32'd0;
        end else if (en) begin
            m_acc   = sum[31:0];
            m_phase = sum[31:22] + off;
            e.pv    = 1'b1;
            e.wr    = sum[32];
            if (was_pending && sum[32]) begin
                m_tw      = m_pend;
                m_pending = 1'b0;
            end
        end
        if (!was_pending && tv) begin
            if (sm) begin
                m_pend    = tw;
                m_pending = 1'b1;
            end else begin
                m_tw = tw;
            end
        end
        e.ph  = m_phase;
        e.rdy = !m_pending;
    endtask

    task automatic apply(input logic en, input logic tv, input logic sm, input logic [31:0] tw,
                         input logic [9:0] off, input logic clr, input exp_t e, input string tag);
        exp_t got;
        sb_q.push_back(e);
        enable = en; tw_valid = tv; sync_mode = sm; tw_data = tw; offset = off; phase_clr = clr;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check({tag, ".valid"}, {31'd0, phase_valid}, {31'd0, got.pv});
            check({tag, ".phase"}, {22'd0, phase}, {22'd0, got.ph});
            check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, got.wr});
            check({tag, ".ready"}, {31'd0, tw_ready}, {31'd0, got.rdy});
        end
    endtask

    task automatic run(input logic en, input logic tv, input logic sm, input logic [31:0] tw,
                       input logic [9:0] off, input logic clr, input string tag);
        exp_t e;
        model_step(en, tv, sm, tw, off, clr, e);
        apply(en, tv, sm, tw, off, clr, e, tag);
    endtask

    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; enable4 = 1'b0; tw_valid = 1'b0; sync_mode = 1'b0;
        tw_data = 32'd0; offset = 10'd0; phase_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   ticks;
        int   wrap_tick;
        logic [9:0] wrap_phase;
        int   en_edges;
        int   last_edge;
        int   strobes;
        logic pat[19];
        exp_t e;

        tbl[0]  = mk(1'b0, 32'h0040_0000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
        tbl[1]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h001, 1'b1, 1'b0, 1'b1);
        tbl[2]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h002, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h200, 1'b0, 10'h203, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h203, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b1, 10'h203, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h001, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b1, 32'h0100_0000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h002, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h000, 1'b0, 10'h006, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 32'h0000_0000, 1'b1, 1'b0, 10'h000, 1'b0, 10'h00A, 1'b1, 1'b0, 1'b1);
        tbl[10] = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h200, 1'b0, 10'h20A, 1'b1, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h200, 1'b1, 10'h20A, 1'b0, 1'b0, 1'b1);
        tbl[12] = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h200, 1'b0, 10'h200, 1'b1, 1'b0, 1'b1);
        tbl[13] = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h200, 1'b0, 10'h200, 1'b1, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 10'h010, 1'b0, 10'h010, 1'b1, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 32'h0040_0000, 1'b1, 1'b1, 10'h010, 1'b0, 10'h010, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 10'h010, 1'b0, 10'h010, 1'b1, 1'b0, 1'b0);

        rst = 1'b0; enable = 1'b0; enable4 = 1'b0; tw_valid = 1'b0; sync_mode = 1'b0;
        tw_data = 32'd0; offset = 10'd0; phase_clr = 1'b0;
        #1;
        check("reset.phase", {22'd0, phase}, 32'd0);
        check("reset.valid", {31'd0, phase_valid}, 32'd0);
        check("reset.ready", {31'd0, tw_ready}, 32'd1);
        check("reset.ready4", {31'd0, tw_ready4}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            e.ph = tbl[i].ph; e.pv = tbl[i].pv; e.wr = tbl[i].wr; e.rdy = tbl[i].rdy;
            apply(tbl[i].en, tbl[i].tv, tbl[i].sm, tbl[i].tw, tbl[i].off, tbl[i].clr, e,
                  $sformatf("vec%0d", i));
        end

        // Asynchronous reset while a word is pending: outputs clear without a clock edge.
        rst = 1'b0;
        #1;
        check("async_rst.phase", {22'd0, phase}, 32'd0);
        check("async_rst.valid", {31'd0, phase_valid}, 32'd0);
        check("async_rst.wrap", {31'd0, wrap}, 32'd0);
        check("async_rst.ready", {31'd0, tw_ready}, 32'd1);
        do_reset();

        // Full revolution at step 1: wrap on tick 1024 with phase 0.
        run(1'b0, 1'b1, 1'b0, 32'h0040_0000, 10'h000, 1'b0, "ld1");
        ticks = 0; wrap_tick = 0; wrap_phase = 10'h3FF;
        for (int i = 0; i < 1100; i++) begin
            run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "rev");
            if (phase_valid) ticks++;
            if (wrap) begin
                wrap_tick = ticks;
                wrap_phase = phase;
                break;
            end
        end
        check("rev.wrap_tick", wrap_tick, 32'd1024);
        check("rev.wrap_phase", {22'd0, wrap_phase}, 32'd0);

        // Sync-mode load at phase 0x100: old step until the wrap, new step after.
        for (int i = 0; i < 300 && phase !== 10'h100; i++) begin
            run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "seek100");
        end
        check("sync.start_phase", {22'd0, phase}, 32'h100);
        run(1'b1, 1'b1, 1'b1, 32'h0080_0000, 10'h000, 1'b0, "sync_ld");
        check("sync.ready_low", {31'd0, tw_ready}, 32'd0);
        ticks = 0; wrap_tick = 0;
        for (int i = 0; i < 1000; i++) begin
            run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "sync_run");
            if (phase_valid) ticks++;
            if (wrap) begin
                wrap_tick = ticks;
                break;
            end
        end
        check("sync.ticks_to_wrap", wrap_tick, 32'd767);
        check("sync.wrap_phase", {22'd0, phase}, 32'd0);
        check("sync.ready_back", {31'd0, tw_ready}, 32'd1);
        run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "step2a");
        check("sync.step2a", {22'd0, phase}, 32'd2);
        run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "step2b");
        check("sync.step2b", {22'd0, phase}, 32'd4);

        // Clear coincident with a tick at phase 0x155.
        run(1'b1, 1'b1, 1'b0, 32'h0040_0000, 10'h000, 1'b0, "ld_step1");
        for (int i = 0; i < 500 && phase !== 10'h155; i++) begin
            run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "seek155");
        end
        check("clr.start_phase", {22'd0, phase}, 32'h155);
        run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b1, "clr");
        check("clr.no_strobe", {31'd0, phase_valid}, 32'd0);
        run(1'b1, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "after_clr");
        check("clr.next_phase", {22'd0, phase}, 32'd1);

        // Divider of 4 with enable dropped for three clocks mid-count.
        do_reset();
        run(1'b0, 1'b1, 1'b0, 32'h0040_0000, 10'h000, 1'b0, "ld4");
        for (int i = 0; i < 19; i++) pat[i] = !(i >= 6 && i < 9);
        en_edges = 0; last_edge = 0; strobes = 0;
        for (int i = 0; i < 19; i++) begin
            enable4 = pat[i];
            run(1'b0, 1'b0, 1'b0, 32'd0, 10'h000, 1'b0, "div4");
            if (pat[i]) en_edges++;
            if (phase_valid4) begin
                strobes++;
                if (strobes == 1) check("div4.first_tick", en_edges, 32'd4);
                else check("div4.spacing", en_edges - last_edge, 32'd4);
                last_edge = en_edges;
            end
            if (!pat[i]) check("div4.frozen_valid", {31'd0, phase_valid4}, 32'd0);
            check("div4.phase", {22'd0, phase4}, strobes);
            check("div4.wrap", {31'd0, wrap4}, 32'd0);
        end
        check("div4.strobes", strobes, 32'd4);
        check("div4.ready", {31'd0, tw_ready4}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dds_phase_gen.md
DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase accumulator width (ACC_W >= `ROM_PHASE_BIT).
REQ-002 SHALL have parameter SAMPLE_DIV, default 4, clocks per sample tick (>= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  run; low freezes the accumulator and the tick divider.
REQ-006 SHALL have port tw_data  input  ACC_W  frequency tuning word.
REQ-007 SHALL have port tw_valid  input  1  tuning word offered.
REQ-008 SHALL have port tw_ready  output  1  tuning word can be accepted.
REQ-009 SHALL have port sync_mode  input  1  0 = apply the word on the next tick; 1 = apply it on the accumulator wrap.
REQ-010 SHALL have port offset  input  `ROM_PHASE_BIT  phase offset added to the output.
REQ-011 SHALL have port phase_clr  input  1  synchronous accumulator clear.
REQ-012 SHALL have port phase  output  `ROM_PHASE_BIT  sine ROM address.
REQ-013 SHALL have port phase_valid  output  1  one-cycle strobe: phase updated.
REQ-014 SHALL have port wrap  output  1  one-cycle strobe with phase_valid when the accumulator overflowed on that tick.

Function
REQ-015 Divider SHALL count 0..SAMPLE_DIV-1 while enable=1 and emit tick when the count equals SAMPLE_DIV-1; enable=0 SHALL hold the count and suppress ticks.
REQ-016 On a tick, acc SHALL become (acc + tw_active) mod 2^ACC_W; carry-out SHALL set the wrap flag for that tick.
REQ-017 phase SHALL be registered as (acc_next[ACC_W-1 -: `ROM_PHASE_BIT] + offset) mod 2^`ROM_PHASE_BIT, with phase_valid=1 in the same cycle it updates, i.e. one clock after the tick.
REQ-018 ROM value for a phase SHALL be valid one further clock after phase_valid; total tick-to-sample latency is 2 clocks.
REQ-019 Load FSM SHALL have states IDLE (tw_ready=1) and PENDING (tw_ready=0).
REQ-020 In IDLE, when tw_valid&&tw_ready and sync_mode=0: tw_active SHALL take tw_data at the same edge; the FSM SHALL stay IDLE.
REQ-021 In IDLE, when tw_valid&&tw_ready and sync_mode=1: tw_data SHALL be stored in tw_pend and the FSM SHALL go to PENDING.
REQ-022 In PENDING, on a tick producing carry-out, that tick SHALL still use the old tw_active; tw_active<=tw_pend afterwards and the FSM SHALL return to IDLE.
REQ-023 phase_clr=1 SHALL set acc<=0 at the next edge, with priority over a coincident tick; that tick SHALL produce neither phase_valid nor wrap; the FSM state and tw_pend SHALL be kept.
REQ-024 tw_active=0 SHALL hold acc constant with phase_valid still strobing, and SHALL never produce wrap.
REQ-025 offset changes SHALL affect only the next phase_valid update, never acc.

Reset
REQ-026 rst=0 SHALL asynchronously clear acc, tw_active, tw_pend, the divider, phase, phase_valid and wrap to 0, set the FSM to IDLE and tw_ready=1, and drop any pending word.
REQ-027 Release SHALL take effect on the first posedge with rst=1; no tick SHALL occur earlier than SAMPLE_DIV clocks after release.

Structure
REQ-028 `ROM_PHASE_BIT and `ROM_PHASE_MAX_VAL SHALL come from the shared DDS defines file; the FSM state encodings SHALL be local constants.
REQ-029 The divider SHALL be a sub-module dds_sample_tick (ports clk, rst, enable, tick).

Verification (ROM_PHASE_BIT=10, ACC_W=32, SAMPLE_DIV=1 unless stated)
REQ-030 Reset asserted mid-run with PENDING -> phase=0, phase_valid=0, wrap=0, tw_ready=1 immediately, without waiting for a clock edge.
REQ-031 tw=0x0040_0000, sync_mode=0, enable=1 -> phase 0,1,2,... one per clock; wrap coincides with phase=0 after exactly 1024 ticks.
REQ-032 tw=0, offset=0x200 -> phase=0x200 on every strobe, no wrap; offset changed to 0x010 -> next strobe phase=0x010.
REQ-033 Running tw=0x0040_0000, load 0x0080_0000 with sync_mode=1 at phase 0x100 -> tw_ready=0 until wrap; step 1 up to and including the wrap; step 2 afterwards (0,2,4,...).
REQ-034 phase_clr coincident with a tick at phase 0x155 -> no strobe that cycle; next strobe phase=0x001 (with offset=0).
REQ-035 SAMPLE_DIV=4, enable toggled low for 3 clocks mid-count -> tick spacing of exactly 4 enabled clocks; phase frozen while disabled.
